// File: rtl/md_wb_sched_if.sv
// Bundle between the E/D/W pipeline stages and the mul/div write-back scheduler.
`default_nettype none

interface md_wb_sched_if;
  logic       md_start_e;
  logic [2:0] md_op_e;
  logic       md_divz_e;
  logic [4:0] rd_e;
  logic       flush_e;
  logic       md_req_d;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_d;
  logic       reg_write_d;
  logic       reg_write_w;
  logic       md_go;
  logic [2:0] md_op_q;
  logic       md_busy;
  logic       md_stall;
  logic       rf_sel_md;
  logic       rf_we_md;
  logic [4:0] rf_rd_md;

  modport master (
    output md_start_e, md_op_e, md_divz_e, rd_e, flush_e,
    output md_req_d, rs1_d, rs2_d, rd_d, reg_write_d, reg_write_w,
    input  md_go, md_op_q, md_busy, md_stall, rf_sel_md, rf_we_md, rf_rd_md
  );

  modport slave (
    input  md_start_e, md_op_e, md_divz_e, rd_e, flush_e,
    input  md_req_d, rs1_d, rs2_d, rd_d, reg_write_d, reg_write_w,
    output md_go, md_op_q, md_busy, md_stall, rf_sel_md, rf_we_md, rf_rd_md
  );
endinterface

`default_nettype wire

// File: rtl/md_wb_sched.sv
// md_wb_sched: issue/hazard/write-port scheduler for a multi-cycle RV32M unit.
// Optional macro MD_DIVZ_EARLY_EN: divide-by-zero ops complete after one cycle.
`default_nettype none

module md_wb_sched #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input logic         clk,
  input logic         rst,
  md_wb_sched_if.slave md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       rd_pend;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] lat_m1;
  logic             accept;
  logic             grant;
  logic             holding;
  logic             raw_hit;
  logic             waw_hit;

`ifdef MD_DIVZ_EARLY_EN
  always_comb begin
    if (md.md_op_e[2] && md.md_divz_e)
      lat_m1 = '0;
    else if (md.md_op_e[2])
      lat_m1 = CNT_W'(DIV_LAT - 1);
    else
      lat_m1 = CNT_W'(MUL_LAT - 1);
  end
`else
  logic unused_divz;
  assign unused_divz = md.md_divz_e;
  assign lat_m1 = md.md_op_e[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
`endif

  // Gated by rst so no start strobe escapes while the block is being reset.
  assign accept  = !rst && (state == IDLE) && md.md_start_e && !md.flush_e;
  assign grant   = (state == DONE) && !md.reg_write_w;
  assign holding = (state == BUSY) || ((state == DONE) && !grant);
  assign raw_hit = (rd_pend != 5'd0) && ((md.rs1_d == rd_pend) || (md.rs2_d == rd_pend));
  assign waw_hit = md.reg_write_d && (md.rd_d == rd_pend) && (rd_pend != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_pend <= 5'd0;
      op_q    <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        rd_pend <= md.rd_e;
        op_q    <= md.md_op_e;
      end
    end
  end

  // cnt holds the BUSY cycles still to go, so DONE is reached lat cycles after accept.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = lat_m1;
          state_nx = (lat_m1 == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CNT_W'(1))
          state_nx = DONE;
      end
      DONE: begin
        if (grant)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign md.md_go     = accept;
  assign md.md_op_q   = op_q;
  assign md.md_busy   = (state != IDLE);
  assign md.md_stall  = (holding && (raw_hit || waw_hit || md.md_req_d)) ||
                        ((state == DONE) && md.reg_write_w);
  assign md.rf_sel_md = grant;
  assign md.rf_we_md  = grant && (rd_pend != 5'd0);
  assign md.rf_rd_md  = (state != IDLE) ? rd_pend : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_md_wb_sched.sv
// Self-checking bench for md_wb_sched: directed scenarios plus random traffic vs a cycle model.
`default_nettype none

module tb_md_wb_sched;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: an in-flight op and the number of cycles until its result is ready.
  bit         m_active = 0;
  logic [4:0] m_rd = 5'd0;
  logic [2:0] m_op = 3'd0;
  int         m_rem = 0;
  int         m_wait = 0;

  md_wb_sched_if bus ();

  md_wb_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int op_lat(input logic [2:0] op, input logic divz);
    int l;
    l = op[2] ? DIV_LAT : MUL_LAT;
`ifdef MD_DIVZ_EARLY_EN
    if (op[2] && divz) l = 1;
`else
    if (divz) l = l;
`endif
    return l;
  endfunction

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic step(input logic r, input logic start, input logic [2:0] op, input logic divz,
                      input logic [4:0] rde, input logic flush, input logic mreq,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdd,
                      input logic rwd, input logic rww);
    bit ready, grant, holding, e_go, e_stall;
    @(negedge clk);
    rst = r;
    bus.md_start_e = start; bus.md_op_e = op; bus.md_divz_e = divz; bus.rd_e = rde;
    bus.flush_e = flush; bus.md_req_d = mreq; bus.rs1_d = rs1; bus.rs2_d = rs2;
    bus.rd_d = rdd; bus.reg_write_d = rwd; bus.reg_write_w = rww;
    #1;
    ready   = m_active && (m_rem == 0);
    grant   = ready && !rww;
    holding = m_active && !grant;
    e_go    = !r && !m_active && start && !flush;
    e_stall = (holding && ((m_rd != 0 && (rs1 == m_rd || rs2 == m_rd)) ||
                           (rwd && rdd == m_rd && m_rd != 0) || mreq)) || (ready && rww);
    check("md_go",     32'(bus.md_go),     32'(e_go));
    check("md_busy",   32'(bus.md_busy),   32'(m_active));
    check("md_stall",  32'(bus.md_stall),  32'(e_stall));
    check("rf_sel_md", 32'(bus.rf_sel_md), 32'(grant));
    check("rf_we_md",  32'(bus.rf_we_md),  32'(grant && m_rd != 0));
    check("rf_rd_md",  32'(bus.rf_rd_md),  32'(m_active ? m_rd : 5'd0));
    check("md_op_q",   32'(bus.md_op_q),   32'(m_op));
    if (r) begin
      m_active = 0; m_rd = 0; m_op = 0; m_rem = 0; m_wait = 0;
    end else if (grant) begin
      m_active = 0;
    end else if (e_go) begin
      m_active = 1; m_rd = rde; m_op = op; m_rem = op_lat(op, divz) - 1; m_wait = 0;
    end else if (m_active && m_rem > 0) begin
      m_rem--;
    end else if (ready && rww) begin
      m_wait++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.md_start_e = 0; bus.md_op_e = 0; bus.md_divz_e = 0; bus.rd_e = 0; bus.flush_e = 0;
    bus.md_req_d = 0; bus.rs1_d = 0; bus.rs2_d = 0; bus.rd_d = 0; bus.reg_write_d = 0;
    bus.reg_write_w = 0;
    step(1, 0, 3'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 3'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    check("reset_busy", 32'(bus.md_busy), 32'd0);

    // MUL x5: go in cycle 0, write in cycle 3, idle in cycle 4
    step(0, 1, 3'd0, 0, 5'd5, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("mul_go", 32'(bus.md_go), 32'd1);
    idle(2);
    idle(1);
    check("mul_we", 32'(bus.rf_we_md), 32'd1);
    check("mul_rd", 32'(bus.rf_rd_md), 32'd5);
    idle(1);
    check("mul_idle", 32'(bus.md_busy), 32'd0);

    // DIV x7 with a dependent D-stage reader: stall cycles 1..15, write in 16
    step(0, 1, 3'd4, 0, 5'd7, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int c = 1; c <= 15; c++) begin
      step(0, 0, 3'd0, 0, 5'd0, 0, 0, 5'd7, 5'd0, 5'd0, 0, 0);
      check("div_raw_stall", 32'(bus.md_stall), 32'd1);
    end
    step(0, 0, 3'd0, 0, 5'd0, 0, 0, 5'd7, 5'd0, 5'd0, 0, 0);
    check("div_grant_stall", 32'(bus.md_stall), 32'd0);
    check("div_we", 32'(bus.rf_we_md), 32'd1);
    check("div_rd", 32'(bus.rf_rd_md), 32'd7);

    // MUL x3 meets two cycles of W-stage writes
    step(0, 1, 3'd1, 0, 5'd3, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    for (int c = 0; c < 2; c++) begin
      step(0, 0, 3'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
      check("port_stall", 32'(bus.md_stall), 32'd1);
      check("port_we", 32'(bus.rf_we_md), 32'd0);
    end
    idle(1);
    check("port_we_late", 32'(bus.rf_we_md), 32'd1);

    // Issue under flush, then reset during BUSY
    step(0, 1, 3'd0, 0, 5'd4, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("flush_go", 32'(bus.md_go), 32'd0);
    idle(1);
    check("flush_busy", 32'(bus.md_busy), 32'd0);
    step(0, 1, 3'd5, 0, 5'd6, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    step(1, 0, 3'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    check("rst_busy", 32'(bus.md_busy), 32'd0);
    check("rst_rd", 32'(bus.rf_rd_md), 32'd0);

    // DIV x9 with divisor zero
    step(0, 1, 3'd4, 1, 5'd9, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
`ifdef MD_DIVZ_EARLY_EN
    idle(1);
`else
    idle(16);
`endif
    check("divz_we", 32'(bus.rf_we_md), 32'd1);
    check("divz_rd", 32'(bus.rf_rd_md), 32'd9);

    // Random traffic; W-stage writes never hold a finished op for more than two cycles
    for (int i = 0; i < 3000; i++) begin
      logic r, rww;
      r   = ($urandom_range(0, 99) == 0);
      rww = ($urandom_range(0, 2) == 0);
      if (m_active && m_rem == 0 && m_wait >= 2) rww = 0;
      step(r, 1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), rww);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
